// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: register file for the MIPS_Lite datapath.
// It has two combinational read ports, one write port whose destination is
// rd_addr or rs_addr, and an optional hardwired-zero entry 0. A clear engine
// zeroes one entry per cycle when clr_req is seen.
// Optional macro REGFILE_BYPASS_EN: when it is defined, a write in flight is
// forwarded to any read port whose address matches the write address.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | normal operation; writes accepted, clr_req starts a clear
// ST_CLEAR | one entry zeroed per cycle at cnt_q; writes rejected
module reg_file_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              dest_sel,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] save_data,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              cnt_last;
    logic              wr_zero;
    logic              wr_ok;
    logic              wr_drop_q;

    assign waddr    = dest_sel ? rs_addr : rd_addr;
    assign cnt_last = (cnt_q == ADDR_W'(DEPTH - 1));
    // A write to entry 0 is discarded silently when entry 0 is hardwired.
    assign wr_zero  = (ZERO_REG != 0) && (waddr == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clr_req is ignored while a clear is already running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clr_req)  state_d = ST_CLEAR;
            ST_CLEAR: if (cnt_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode: busy comes straight from the state flop
    always_comb begin
        busy  = (state_q == ST_CLEAR);
        wr_ok = wr_en && (state_q == ST_IDLE) && !wr_zero;
    end

    // Clear counter: held at 0 in IDLE, so a new clear always starts at entry 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            cnt_q <= cnt_q + ADDR_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Storage array: the clear engine has priority, and writes are blocked while busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem_q[waddr] <= wr_data;
        end
    end

    // Rejected-write flag: one pulse for each cycle in which a write is refused
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_en && (state_q == ST_CLEAR);
        end
    end

    assign wr_drop = wr_drop_q;

    // Read ports, with the hardwired zero and the optional write forwarding
    always_comb begin
        rs_data = mem_q[rs_addr];
        rt_data = mem_q[rt_addr];
        if ((ZERO_REG != 0) && (rs_addr == '0)) rs_data = '0;
        if ((ZERO_REG != 0) && (rt_addr == '0)) rt_data = '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (rs_addr == waddr)) rs_data = wr_data;
        if (wr_ok && (rt_addr == waddr)) rt_data = wr_data;
`else
`endif
        save_data = rs_data;
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl. Two instances share the same stimulus:
// dut_a has an ordinary entry 0, and dut_z has a hardwired-zero entry 0.
module tb_reg_file_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rs_addr, rt_addr, rd_addr;
    logic       dest_sel, wr_en, clr_req;
    logic [7:0] wr_data;
    logic [7:0] rs_data, rt_data, save_data;
    logic       busy, wr_drop;
    logic [7:0] z_rs_data, z_rt_data, z_save_data;
    logic       z_busy, z_wr_drop;

    int total = 0;
    int bad   = 0;
    logic [7:0] em [8];
    int  nbusy;
    bit  done;
    bit  byp;

    always #5 clk = ~clk;

    reg_file_ctrl #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut_a (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .dest_sel(dest_sel), .wr_en(wr_en),
        .wr_data(wr_data), .clr_req(clr_req), .rs_data(rs_data),
        .rt_data(rt_data), .save_data(save_data), .busy(busy),
        .wr_drop(wr_drop)
    );

    reg_file_ctrl #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .dest_sel(dest_sel), .wr_en(wr_en),
        .wr_data(wr_data), .clr_req(clr_req), .rs_data(z_rs_data),
        .rt_data(z_rt_data), .save_data(z_save_data), .busy(z_busy),
        .wr_drop(z_wr_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        dest_sel = 1'b0;
        rd_addr  = a;
        wr_data  = d;
        wr_en    = 1'b1;
        tick();
        wr_en    = 1'b0;
        em[a]    = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef REGFILE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        rst = 1'b0; rs_addr = '0; rt_addr = '0; rd_addr = '0;
        dest_sel = 1'b0; wr_en = 1'b0; clr_req = 1'b0; wr_data = '0;
        for (int i = 0; i < 8; i++) em[i] = '0;
        #12;
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_drop", wr_drop, 0);
        chk("rst_zbusy", z_busy, 0);
        for (int a = 0; a < 8; a++) begin
            rs_addr = 3'(a); rt_addr = 3'(7 - a); #1;
            chk("rst_rs", rs_data, 0);
            chk("rst_rt", rt_data, 0);
        end

        // write through rd_addr, observed on rt
        dest_sel = 1'b0; rd_addr = 3'd5; wr_data = 8'hA5; wr_en = 1'b1; rt_addr = 3'd5; #1;
        chk("rt_same_cycle", rt_data, byp ? 8'hA5 : 8'h00);
        tick(); wr_en = 1'b0; em[5] = 8'hA5; #1;
        chk("rt_after_wr", rt_data, 8'hA5);

        // write through rs_addr (dest_sel=1)
        dest_sel = 1'b1; rs_addr = 3'd3; wr_data = 8'h3C; wr_en = 1'b1;
        tick(); wr_en = 1'b0; dest_sel = 1'b0; em[3] = 8'h3C; #1;
        chk("rs_dest", rs_data, 8'h3C);
        chk("save_dest", save_data, 8'h3C);
        chk("rt_keep5", rt_data, 8'hA5);

        // entry 0 write: ordinary vs hardwired zero
        rd_addr = 3'd0; wr_data = 8'hFF; wr_en = 1'b1; rs_addr = 3'd0; #1;
        chk("z0_same_cycle", z_rs_data, 0);
        tick(); wr_en = 1'b0; em[0] = 8'hFF; #1;
        chk("a0_rs", rs_data, 8'hFF);
        chk("z0_rs", z_rs_data, 0);
        chk("z0_drop", z_wr_drop, 0);
        chk("a0_drop", wr_drop, 0);

        // fill all entries
        for (int k = 0; k < 8; k++) wr(3'(k), 8'(8'h10 + k));
        for (int k = 0; k < 8; k++) begin
            rs_addr = 3'(k); #1;
            chk("fill_rs", rs_data, em[k]);
            chk("fill_zrs", z_rs_data, (k == 0) ? 8'h00 : em[k]);
        end

        // forwarding of a write to entry 2
        rd_addr = 3'd2; wr_data = 8'h77; wr_en = 1'b1; rs_addr = 3'd2; #1;
        chk("byp_rs", rs_data, byp ? 8'h77 : 8'h12);
        chk("byp_save", save_data, byp ? 8'h77 : 8'h12);
        tick(); wr_en = 1'b0; em[2] = 8'h77; #1;
        chk("byp_next", rs_data, 8'h77);

        // clear sweep: entry k reads 0 after edge k+1
        clr_req = 1'b1; tick(); clr_req = 1'b0; rs_addr = 3'd0; #1;
        chk("clr_busy0", busy, 1);
        chk("clr_e0_kept", rs_data, em[0]);
        for (int k = 0; k < 8; k++) begin
            tick();
            rs_addr = 3'(k); rt_addr = 3'((k + 1) % 8); #1;
            chk("clr_busy", busy, (k < 7) ? 1 : 0);
            chk("clr_rs", rs_data, 0);
            chk("clr_rt", rt_data, (k < 7) ? em[k + 1] : 8'h00);
        end
        for (int i = 0; i < 8; i++) em[i] = '0;

        // rejected write during a clear, plus a repeated clr_req
        clr_req = 1'b1; tick(); clr_req = 1'b0; #1;
        nbusy = busy ? 1 : 0;
        done  = 1'b0;
        for (int i = 1; i <= 20 && !done; i++) begin
            if (i == 3) begin
                rd_addr = 3'd0; wr_data = 8'h99; wr_en = 1'b1; clr_req = 1'b1; rs_addr = 3'd0; #1;
                chk("busy_no_byp", rs_data, 0);
            end
            tick(); wr_en = 1'b0; clr_req = 1'b0; #1;
            if (i == 3) chk("drop_pulse", wr_drop, 1);
            if (i == 4) chk("drop_end", wr_drop, 0);
            if (busy) nbusy++; else done = 1'b1;
        end
        chk("busy_len", nbusy, 8);
        rs_addr = 3'd0; #1;
        chk("drop_no_write", rs_data, 0);

        // write and clr_req on the same edge, clr_req held high
        rd_addr = 3'd4; wr_data = 8'h44; wr_en = 1'b1; clr_req = 1'b1;
        tick(); wr_en = 1'b0; rs_addr = 3'd4; #1;
        chk("same_edge_busy", busy, 1);
        chk("same_edge_wr", rs_data, 8'h44);
        repeat (7) tick();
        #1;
        chk("held_busy7", busy, 1);
        tick(); #1;
        chk("held_idle", busy, 0);
        chk("same_edge_cleared", rs_data, 0);
        tick(); #1;
        chk("held_restart", busy, 1);
        clr_req = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        chk("restart_end", busy, 0);

        // reset in the middle of a clear
        for (int k = 0; k < 8; k++) wr(3'(k), 8'(8'hA0 + k));
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        repeat (3) tick();
        rs_addr = 3'd7; #1;
        chk("mid_rs7", rs_data, 8'hA7);
        chk("mid_busy", busy, 1);
        #1; rst = 1'b0; #1;
        chk("arst_busy", busy, 0);
        chk("arst_drop", wr_drop, 0);
        for (int a = 0; a < 8; a++) begin
            rs_addr = 3'(a); rt_addr = 3'(a); #1;
            chk("arst_rs", rs_data, 0);
            chk("arst_rt", rt_data, 0);
        end
        rst = 1'b1;
        tick(); #1;
        chk("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
Parametrised multi-port register file for the MIPS_Lite datapath. It provides two combinational read ports, one write port with selectable destination (rd or rs), and an optional hardwired-zero register. A sequential clear engine wipes the file one entry per cycle on request, and an optional write-to-read bypass is available.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 0, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
rs_addr  input  ADDR_W  read port A address; also the destination when dest_sel=1
rt_addr  input  ADDR_W  read port B address
rd_addr  input  ADDR_W  destination when dest_sel=0
dest_sel  input  1  0 = write to rd_addr (arithmetic); 1 = write to rs_addr (load/save)
wr_en  input  1  write request
wr_data  input  DATA_W  write data
clr_req  input  1  start a sequential clear (pulse or level)
rs_data  output  DATA_W  read data for rs_addr
rt_data  output  DATA_W  read data for rt_addr
save_data  output  DATA_W  copy of rs_data, used by the store path
busy  output  1  high while the clear engine runs
wr_drop  output  1  one-cycle pulse when a write is rejected because busy is high

Behaviour:
- Reset (rst=0), asynchronous: all DEPTH entries go to 0, FSM goes to IDLE, clear counter goes to 0, busy=0, wr_drop=0. All read outputs are therefore 0.
- Destination address: waddr = dest_sel ? rs_addr : rd_addr.
- Write, in IDLE: when wr_en=1, entry[waddr] <= wr_data at the rising edge.
  - If ZERO_REG=1 and waddr=0, the write is discarded silently and wr_drop stays 0.
- Reads are combinational from the array.
  - rs_data = entry[rs_addr]; rt_data = entry[rt_addr]; save_data = rs_data.
  - If ZERO_REG=1, address 0 always reads 0.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on a rising edge with clr_req=1. The counter loads 0.
  - In CLEAR, each cycle entry[cnt] <= 0 and cnt increments.
  - When cnt = DEPTH-1, that entry is cleared and the FSM returns to IDLE; cnt wraps to 0.
  - busy = (state == CLEAR), registered. busy is high for exactly DEPTH cycles, starting the cycle after clr_req is sampled.
- clr_req while in CLEAR is ignored: the clear does not restart or extend.
- If clr_req stays high after the clear completes, a new clear starts on the next edge, because the FSM is back in IDLE.
- wr_en=1 while busy=1: the write is not performed; wr_drop=1 for the following cycle, registered, one pulse per rejected cycle.
- wr_en=1 and clr_req=1 on the same IDLE edge: the write is performed on that edge, then the clear starts and erases it.
- Reads during CLEAR return live array contents, so the file is partially cleared; bypass never applies while busy.
- rst asserted mid-clear: the array is zeroed immediately and the FSM aborts to IDLE with busy=0.

Optional Feature:
REGFILE_BYPASS_EN:
- Defined: a read port whose address equals waddr, while wr_en=1 and busy=0 (and not a discarded ZERO_REG write), returns wr_data combinationally in the same cycle. This applies to rs_data, rt_data and save_data.
- Undefined: reads always return the stored value, so newly written data becomes visible the cycle after the write edge.

Test Plan:
- Release rst with no other activity, sweep rs_addr/rt_addr over 0..7 -> all reads 0; busy=0, wr_drop=0.
- dest_sel=0, rd_addr=5, wr_data=8'hA5, wr_en=1 for one edge, then rt_addr=5 -> rt_data=8'hA5. Repeat with dest_sel=1, rs_addr=3, wr_data=8'h3C -> entry 3 = 8'h3C, entry 5 unchanged.
- ZERO_REG=1: write 8'hFF to addr 0 -> rs_data at addr 0 reads 0 and wr_drop=0. ZERO_REG=0: same write -> reads 8'hFF.
- Fill all 8 entries with nonzero data, pulse clr_req for one cycle -> busy high for exactly 8 cycles; entry k reads 0 from cycle k+1 after the pulse; all entries 0 when busy falls.
- wr_en=1 during busy -> wr_drop pulses 1 cycle later and the target entry is not updated. clr_req re-pulsed mid-clear -> busy length is still 8 cycles.
- With REGFILE_BYPASS_EN defined: write 8'h77 to addr 2 while rs_addr=2 -> rs_data=8'h77 in the same cycle. Without it -> old value that cycle, 8'h77 the next. Additionally, assert rst at cycle 4 of a clear -> busy drops asynchronously and all entries read 0.
